// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller: channel FSM
// encodings, configuration select codes and status codes.
package fan_ctrl_pkg;

    typedef logic [1:0] ch_state_t;

    localparam ch_state_t ST_OFF   = 2'd0;
    localparam ch_state_t ST_KICK  = 2'd1;
    localparam ch_state_t ST_RUN   = 2'd2;
    localparam ch_state_t ST_STALL = 2'd3;

    typedef enum logic [1:0] {
        SEL_DUTY   = 2'd0,
        SEL_MIN    = 2'd1,
        SEL_PERIOD = 2'd2,
        SEL_CLEAR  = 2'd3
    } cfg_sel_e;

    localparam logic [3:0] STATUS_OK    = 4'hA;
    localparam logic [3:0] STATUS_STALL = 4'hE;

endpackage

// File: rtl/fan_channel.sv
// One fan channel: shadow/active PWM registers, period counter, kick/run/stall
// FSM and tachometer synchroniser with windowed pulse counter.
module fan_channel
    import fan_ctrl_pkg::*;
#(
    parameter int DUTY_BITWIDTH  = 8,
    parameter int TACH_BITWIDTH  = 12,
    parameter int WINDOW_PERIODS = 25,
    parameter int KICK_PERIODS   = 50,
    parameter int STALL_THRESH   = 2,
    parameter int STALL_RETRIES  = 3
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     tick_i,
    input  logic                     wr_en_i,
    input  logic [1:0]               sel_i,
    input  logic [DUTY_BITWIDTH:0]   data_i,
    input  logic                     tach_i,
    output logic                     pwm_o,
    output logic [TACH_BITWIDTH-1:0] tach_count_o,
    output logic                     tach_valid_o,
    output logic                     stall_o
);

    localparam int PW    = DUTY_BITWIDTH + 1;
    localparam int WIN_W = $clog2(WINDOW_PERIODS + 1);
    localparam int KCK_W = $clog2(KICK_PERIODS + 1);
    localparam int RET_W = $clog2(STALL_RETRIES + 1);

    logic [DUTY_BITWIDTH-1:0] duty_sh_reg, min_sh_reg, duty_act_reg, min_act_reg, eff;
    logic [PW-1:0]            per_sh_reg, per_act_reg, cnt_reg, per_clamp;
    logic [WIN_W-1:0]         win_reg;
    logic [KCK_W-1:0]         kick_reg, kick_next;
    logic [RET_W-1:0]         retry_reg, retry_next;
    logic [TACH_BITWIDTH-1:0] tach_cnt_reg, tach_last_reg;
    logic                     tach_s1_reg, tach_s2_reg, tach_d_reg, tach_valid_reg;
    ch_state_t                state_reg, state_next;
    logic                     wrap, win_end, rise, fail, clr_req, zero_req;

    assign per_clamp = (per_act_reg == '0) ? PW'(1) : per_act_reg;
    assign wrap      = tick_i && (cnt_reg == per_clamp);
    assign win_end   = wrap && (win_reg == WIN_W'(WINDOW_PERIODS - 1));
    assign rise      = tach_s2_reg && !tach_d_reg;
    assign fail      = tach_cnt_reg < TACH_BITWIDTH'(STALL_THRESH);
    assign clr_req   = wr_en_i && (sel_i == SEL_CLEAR);
    assign zero_req  = wr_en_i && (sel_i == SEL_DUTY) && (data_i[DUTY_BITWIDTH-1:0] == '0);
    assign eff       = (duty_act_reg > min_act_reg) ? duty_act_reg : min_act_reg;

    // Decisions at wrap use the shadow values, since those become active at that same edge.
    always_comb begin
        state_next = state_reg;
        kick_next  = kick_reg;
        retry_next = retry_reg;
        case (state_reg)
            ST_OFF: begin
                retry_next = '0;
                if (wrap && duty_sh_reg != '0) begin
                    state_next = ST_KICK;
                    kick_next  = '0;
                end
            end
            ST_KICK: begin
                retry_next = '0;
                if (wrap) begin
                    if (duty_sh_reg == '0)
                        state_next = ST_OFF;
                    else if (kick_reg == KCK_W'(KICK_PERIODS - 1))
                        state_next = ST_RUN;
                    else
                        kick_next = kick_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (win_end)
                    retry_next = fail ? retry_reg + 1'b1 : '0;
                if (wrap) begin
                    if (duty_sh_reg == '0)
                        state_next = ST_OFF;
                    else if (win_end && fail && retry_reg == RET_W'(STALL_RETRIES - 1))
                        state_next = clr_req ? ST_OFF : ST_STALL;
                end
            end
            default: begin
                retry_next = '0;
                if (clr_req || zero_req)
                    state_next = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            duty_sh_reg  <= '0;
            min_sh_reg   <= '0;
            per_sh_reg   <= PW'(255);
            duty_act_reg <= '0;
            min_act_reg  <= '0;
            per_act_reg  <= PW'(255);
            cnt_reg      <= '0;
            win_reg      <= '0;
            state_reg    <= ST_OFF;
            kick_reg     <= '0;
            retry_reg    <= '0;
        end else begin
            if (wr_en_i) begin
                case (sel_i)
                    SEL_DUTY:   duty_sh_reg <= data_i[DUTY_BITWIDTH-1:0];
                    SEL_MIN:    min_sh_reg  <= data_i[DUTY_BITWIDTH-1:0];
                    SEL_PERIOD: per_sh_reg  <= data_i;
                    default:    ;
                endcase
            end
            if (tick_i)
                cnt_reg <= wrap ? '0 : cnt_reg + 1'b1;
            if (wrap) begin
                duty_act_reg <= duty_sh_reg;
                min_act_reg  <= min_sh_reg;
                per_act_reg  <= per_sh_reg;
                win_reg      <= win_end ? '0 : win_reg + 1'b1;
            end
            state_reg <= state_next;
            kick_reg  <= kick_next;
            retry_reg <= retry_next;
        end
    end

    // An edge seen in the window-end cycle belongs to the new window.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tach_s1_reg    <= 1'b0;
            tach_s2_reg    <= 1'b0;
            tach_d_reg     <= 1'b0;
            tach_cnt_reg   <= '0;
            tach_last_reg  <= '0;
            tach_valid_reg <= 1'b0;
        end else begin
            tach_s1_reg    <= tach_i;
            tach_s2_reg    <= tach_s1_reg;
            tach_d_reg     <= tach_s2_reg;
            tach_valid_reg <= win_end;
            if (win_end) begin
                tach_last_reg <= tach_cnt_reg;
                tach_cnt_reg  <= rise ? TACH_BITWIDTH'(1) : '0;
            end else if (rise && tach_cnt_reg != '1) begin
                tach_cnt_reg <= tach_cnt_reg + 1'b1;
            end
        end
    end

    assign pwm_o        = (state_reg == ST_KICK) ||
                          ((state_reg == ST_RUN) && ({1'b0, eff} > cnt_reg));
    assign stall_o      = (state_reg == ST_STALL);
    assign tach_count_o = tach_last_reg;
    assign tach_valid_o = tach_valid_reg;

endmodule

// File: rtl/fan_ctrl_mc.sv
// Multi-channel fan controller top: shared prescaler, valid/ready config
// decode with out-of-range detection, per-channel instances and status.
module fan_ctrl_mc
    import fan_ctrl_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DUTY_BITWIDTH  = 8,
    parameter int PRESC_DIV      = 399,
    parameter int TACH_BITWIDTH  = 12,
    parameter int WINDOW_PERIODS = 25,
    parameter int KICK_PERIODS   = 50,
    parameter int STALL_THRESH   = 2,
    parameter int STALL_RETRIES  = 3,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            clk_en_i,
    input  logic                            cfg_valid_i,
    output logic                            cfg_ready_o,
    input  logic [CH_W-1:0]                 cfg_ch_i,
    input  logic [1:0]                      cfg_sel_i,
    input  logic [DUTY_BITWIDTH:0]          cfg_data_i,
    output logic                            cfg_err_o,
    input  logic [NUM_CH-1:0]               tach_i,
    output logic [NUM_CH-1:0]               pwm_o,
    output logic [NUM_CH*TACH_BITWIDTH-1:0] tach_count_o,
    output logic [NUM_CH-1:0]               tach_valid_o,
    output logic [NUM_CH-1:0]               stall_o,
    output logic [3:0]                      state_o
);

    localparam int PS_W = (PRESC_DIV > 0) ? $clog2(PRESC_DIV + 1) : 1;

    logic [PS_W-1:0]      presc_reg;
    logic                 tick, xfer, cfg_ready_reg, cfg_err_reg;
    logic [2**CH_W-1:0]   ch_exists;

    assign tick = clk_en_i && (presc_reg == PS_W'(PRESC_DIV));
    assign xfer = cfg_valid_i && cfg_ready_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_reg     <= '0;
            cfg_ready_reg <= 1'b1;
            cfg_err_reg   <= 1'b0;
        end else begin
            if (clk_en_i)
                presc_reg <= tick ? '0 : presc_reg + 1'b1;
            cfg_ready_reg <= !xfer;
            cfg_err_reg   <= xfer && !ch_exists[cfg_ch_i];
        end
    end

    // Indices beyond NUM_CH are still accepted so the host never deadlocks.
    for (genvar gi = 0; gi < 2**CH_W; gi++) begin : g_exists
        assign ch_exists[gi] = (gi < NUM_CH);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic wr_en;
        assign wr_en = xfer && (cfg_ch_i == CH_W'(gi));

        fan_channel #(
            .DUTY_BITWIDTH (DUTY_BITWIDTH),
            .TACH_BITWIDTH (TACH_BITWIDTH),
            .WINDOW_PERIODS(WINDOW_PERIODS),
            .KICK_PERIODS  (KICK_PERIODS),
            .STALL_THRESH  (STALL_THRESH),
            .STALL_RETRIES (STALL_RETRIES)
        ) u_ch (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .tick_i      (tick),
            .wr_en_i     (wr_en),
            .sel_i       (cfg_sel_i),
            .data_i      (cfg_data_i),
            .tach_i      (tach_i[gi]),
            .pwm_o       (pwm_o[gi]),
            .tach_count_o(tach_count_o[gi*TACH_BITWIDTH +: TACH_BITWIDTH]),
            .tach_valid_o(tach_valid_o[gi]),
            .stall_o     (stall_o[gi])
        );
    end

    assign cfg_ready_o = cfg_ready_reg;
    assign cfg_err_o   = cfg_err_reg;
    assign state_o     = (|stall_o) ? STATUS_STALL : STATUS_OK;

endmodule

// File: tb/tb_fan_ctrl_mc.sv
// Directed bench for fan_ctrl_mc: PWM shapes, kick, stall/clear, tach windows,
// config handshake/errors and asynchronous reset, with a tick every cycle.
module tb_fan_ctrl_mc;
    import fan_ctrl_pkg::*;

    // Three channels so that index 3 is out of range for the 2-bit channel field.
    localparam int NUM_CH = 3;
    localparam int TW     = 12;

    logic                 clk_i = 1'b0;
    logic                 rstn_i = 1'b1;
    logic                 clk_en_i = 1'b1;
    logic                 cfg_valid_i = 1'b0;
    logic                 cfg_ready_o;
    logic [1:0]           cfg_ch_i = '0;
    logic [1:0]           cfg_sel_i = '0;
    logic [8:0]           cfg_data_i = '0;
    logic                 cfg_err_o;
    logic [NUM_CH-1:0]    tach_i = '0;
    logic [NUM_CH-1:0]    pwm_o;
    logic [NUM_CH*TW-1:0] tach_count_o;
    logic [NUM_CH-1:0]    tach_valid_o;
    logic [NUM_CH-1:0]    stall_o;
    logic [3:0]           state_o;

    int total = 0;
    int bad   = 0;
    int len;
    int n;

    always #5 clk_i = ~clk_i;

    fan_ctrl_mc #(
        .NUM_CH(NUM_CH), .DUTY_BITWIDTH(8), .PRESC_DIV(0), .TACH_BITWIDTH(TW),
        .WINDOW_PERIODS(2), .KICK_PERIODS(2), .STALL_THRESH(2), .STALL_RETRIES(3)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clk_en_i(clk_en_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_ch_i(cfg_ch_i),
        .cfg_sel_i(cfg_sel_i), .cfg_data_i(cfg_data_i), .cfg_err_o(cfg_err_o),
        .tach_i(tach_i), .pwm_o(pwm_o), .tach_count_o(tach_count_o),
        .tach_valid_o(tach_valid_o), .stall_o(stall_o), .state_o(state_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [8:0] data);
        cfg_valid_i = 1'b1; cfg_ch_i = ch; cfg_sel_i = sel; cfg_data_i = data;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    // Length of the current constant-level run on one PWM pin, ending on the first changed cycle.
    task automatic run_len(input int ch, output int cycles);
        logic lvl;
        lvl = pwm_o[ch];
        cycles = 0;
        while (pwm_o[ch] === lvl && cycles < 1000) begin
            cycles++;
            @(negedge clk_i);
        end
    endtask

    task automatic wait_pwm_high(input int ch, input string tag);
        int k = 0;
        while (pwm_o[ch] !== 1'b1 && k < 600) begin
            k++;
            @(negedge clk_i);
        end
        check(tag, pwm_o[ch], 1);
    endtask

    initial begin
        // Reset state
        #2 rstn_i = 1'b0;
        @(negedge clk_i);
        check("rst_pwm", pwm_o, 0);
        check("rst_ready", cfg_ready_o, 1);
        check("rst_err", cfg_err_o, 0);
        check("rst_state", state_o, 4'hA);
        check("rst_stall", stall_o, 0);
        check("rst_tvalid", tach_valid_o, 0);
        check("rst_tcount", tach_count_o, 0);
        rstn_i = 1'b1;

        // Duty on ch0: kick 2 periods, then 3 high / 7 low
        cfg_write(2'd0, SEL_PERIOD, 9'd9);
        cfg_write(2'd0, SEL_DUTY, 9'd3);
        wait_pwm_high(0, "duty_start");
        run_len(0, len); check("kick_plus_high", len, 23);
        run_len(0, len); check("duty_low1", len, 7);
        run_len(0, len); check("duty_high2", len, 3);
        run_len(0, len); check("duty_low2", len, 7);
        check("other_ch_low", pwm_o[2:1], 0);

        // Stall: no tach edges, third failed RUN window lands 30 cycles later
        n = 0;
        while (!stall_o[0] && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        check("stall_delay", n, 30);
        check("stall_state", state_o, 4'hE);
        check("stall_pwm", pwm_o[0], 0);

        // Clear stall takes effect one cycle after acceptance
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd0; cfg_sel_i = SEL_CLEAR; cfg_data_i = '0;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        check("clear_stall", stall_o[0], 0);
        check("clear_state", state_o, 4'hA);
        check("ready_drop", cfg_ready_o, 0);
        @(negedge clk_i);
        check("ready_back", cfg_ready_o, 1);
        wait_pwm_high(0, "rekick_start");
        run_len(0, len); check("rekick_high", len, 23);

        // Tach window: 4 edges, plus one in the window-end cycle
        n = 0;
        while (!tach_valid_o[0] && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check("tvalid_seen", tach_valid_o[0], 1);
        check("tcount_empty", tach_count_o[TW-1:0], 0);
        for (int p = 0; p < 4; p++) begin
            tach_i[0] = 1'b1;
            repeat (2) @(negedge clk_i);
            tach_i[0] = 1'b0;
            repeat (2) @(negedge clk_i);
        end
        @(negedge clk_i);
        tach_i[0] = 1'b1;
        repeat (3) @(negedge clk_i);
        check("tvalid_pulse", tach_valid_o[0], 1);
        check("tcount_4", tach_count_o[TW-1:0], 4);
        @(negedge clk_i);
        check("tvalid_one_cycle", tach_valid_o[0], 0);
        repeat (19) @(negedge clk_i);
        check("tvalid_next", tach_valid_o[0], 1);
        check("tcount_carry", tach_count_o[TW-1:0], 1);
        check("tcount_ch1", tach_count_o[2*TW-1:TW], 0);

        // Min duty on ch1: eff = max(2,5) = 5, then mid-period duty 8
        cfg_write(2'd1, SEL_PERIOD, 9'd9);
        cfg_write(2'd1, SEL_MIN, 9'd5);
        cfg_write(2'd1, SEL_DUTY, 9'd2);
        wait_pwm_high(1, "min_start");
        run_len(1, len); check("min_kick_high", len, 25);
        run_len(1, len); check("min_low", len, 5);
        run_len(1, len); check("min_high", len, 5);
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd1; cfg_sel_i = SEL_DUTY; cfg_data_i = 9'd8;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        run_len(1, len); check("mid_no_runt", len, 4);
        run_len(1, len); check("mid_new_high", len, 8);
        run_len(1, len); check("mid_new_low", len, 2);

        // Out-of-range channel
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd3; cfg_sel_i = SEL_DUTY; cfg_data_i = 9'd7;
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        check("err_pulse", cfg_err_o, 1);
        @(negedge clk_i);
        check("err_one_cycle", cfg_err_o, 0);
        check("err_no_effect", pwm_o[2], 0);

        // Back-to-back valid: ready low every second cycle
        cfg_valid_i = 1'b1; cfg_ch_i = 2'd2; cfg_sel_i = SEL_MIN; cfg_data_i = '0;
        check("b2b_ready0", cfg_ready_o, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_i);
            check($sformatf("b2b_ready%0d", k), cfg_ready_o, (k % 2 == 1) ? 0 : 1);
        end
        cfg_valid_i = 1'b0;

        // Asynchronous reset mid-period
        wait_pwm_high(1, "rst_mid_high");
        check("pre_rst_stall", stall_o, 3'b001);
        rstn_i = 1'b0;
        #1;
        check("arst_pwm", pwm_o, 0);
        check("arst_stall", stall_o, 0);
        check("arst_state", state_o, 4'hA);
        check("arst_ready", cfg_ready_o, 1);
        check("arst_err", cfg_err_o, 0);
        check("arst_tvalid", tach_valid_o, 0);
        check("arst_tcount", tach_count_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
